// File: rtl/sha256_iter_engine.sv
// Iterative SHA-256 compression engine: ROUNDS_PER_CYCLE rounds per clock over a 16-word window.
// Define SHA256_MIDSTATE_EN to start from midstate_in instead of the FIPS IV.
`timescale 1ns / 1ps

module sha256_iter_engine #(
  parameter int unsigned WORDBITS         = 32,
  parameter int unsigned ROUNDS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] msg_in,
  input  logic [255:0] midstate_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] hash_out,
  output logic         busy
);

  localparam int unsigned R         = ROUNDS_PER_CYCLE;
  localparam int unsigned ITERS     = 64 / R;
  localparam logic [5:0]  LAST_RCNT = 6'((ITERS - 1) * R);

  if (WORDBITS != 32) begin : g_bad_wordbits
    $error("sha256_iter_engine: WORDBITS must be 32");
  end
  if (R != 1 && R != 2 && R != 4 && R != 8 && R != 16) begin : g_bad_rounds
    $error("sha256_iter_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2} state_e;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e     state_q;
  logic [5:0] rcnt_q;
  word_t      win_q   [16];
  word_t      st_q    [8];
  word_t      hsave_q [8];

  word_t      init_st [8];
  word_t      ext     [16 + R];
  word_t      nxt_st  [8];

`ifdef SHA256_MIDSTATE_EN
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      init_st[i] = midstate_in[32*i +: 32];
    end
  end
`else
  logic unused_midstate;
  assign unused_midstate = ^midstate_in;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      init_st[i] = IV[i];
    end
  end
`endif

  // Extend the window by R scheduled words; ext[0..R-1] feed this cycle's rounds and
  // ext[R..R+15] become the next window. Words past W63 in the last cycle are discarded.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ext[i] = win_q[i];
    end
    for (int j = 0; j < int'(R); j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end
  end

  always_comb begin
    word_t a, b, c, d, e, f, g, h, t1, t2;
    a  = st_q[0];
    b  = st_q[1];
    c  = st_q[2];
    d  = st_q[3];
    e  = st_q[4];
    f  = st_q[5];
    g  = st_q[6];
    h  = st_q[7];
    t1 = '0;
    t2 = '0;
    for (int j = 0; j < int'(R); j++) begin
      t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[rcnt_q + 6'(j)] + ext[j];
      t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      h  = g;
      g  = f;
      f  = e;
      e  = d + t1;
      d  = c;
      c  = b;
      b  = a;
      a  = t1 + t2;
    end
    nxt_st[0] = a;
    nxt_st[1] = b;
    nxt_st[2] = c;
    nxt_st[3] = d;
    nxt_st[4] = e;
    nxt_st[5] = f;
    nxt_st[6] = g;
    nxt_st[7] = h;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rcnt_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      hash_out  <= '0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        st_q[i]    <= '0;
        hsave_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) begin
              win_q[i] <= msg_in[32*i +: 32];
            end
            for (int i = 0; i < 8; i++) begin
              st_q[i]    <= init_st[i];
              hsave_q[i] <= init_st[i];
            end
            rcnt_q   <= '0;
            state_q  <= StRun;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StRun: begin
          for (int i = 0; i < 16; i++) begin
            win_q[i] <= ext[int'(R) + i];
          end
          for (int i = 0; i < 8; i++) begin
            st_q[i] <= nxt_st[i];
          end
          rcnt_q <= rcnt_q + 6'(R);
          if (rcnt_q == LAST_RCNT) begin
            for (int i = 0; i < 8; i++) begin
              hash_out[32*i +: 32] <= hsave_q[i] + nxt_st[i];
            end
            state_q   <= StDone;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_iter_engine.sv
// Scoreboard bench for sha256_iter_engine: a FIPS-level compression model predicts each hash.
`timescale 1ns / 1ps

module tb_sha256_iter_engine;

  localparam int unsigned MAIN_R     = 4;
  localparam int unsigned MAIN_ITERS = 64 / MAIN_R;
  localparam int          ALT_R [5]  = '{1, 2, 8, 16, 4};

  localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [255:0] ABC_HASH = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                       32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [511:0] ABC_MSG = {32'h00000018, 448'h0, 32'h61626380};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] msg_in;
  logic [255:0] midstate_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] hash_out;
  logic         busy;

  logic [3:0]   alt_ir;
  logic [3:0]   alt_ov;
  logic [3:0]   alt_busy;
  logic [255:0] alt_hash [4];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  int           m_st = 0;  // 0 idle, 1 running, 2 result held
  int           m_cnt = 0;
  logic [255:0] exp_q [$];

  sha256_iter_engine #(
    .WORDBITS        (32),
    .ROUNDS_PER_CYCLE(MAIN_R)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .msg_in     (msg_in),
    .midstate_in(midstate_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .hash_out   (hash_out),
    .busy       (busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_alt
    sha256_iter_engine #(
      .WORDBITS        (32),
      .ROUNDS_PER_CYCLE(ALT_R[g])
    ) u_alt (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (alt_ir[g]),
      .msg_in     (msg_in),
      .midstate_in(midstate_in),
      .out_valid  (alt_ov[g]),
      .out_ready  (1'b1),
      .hash_out   (alt_hash[g]),
      .busy       (alt_busy[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 compression: full 64-word schedule, then 64 rounds.
  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[32*t +: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[32*i +: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[32*i +: 32] = hin[32*i +: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] init_state();
`ifdef SHA256_MIDSTATE_EN
    return midstate_in;
`else
    return IV;
`endif
  endfunction

  // Protocol-level model: accept when idle, result after MAIN_ITERS edges, release on out_ready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st  = 0;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      case (m_st)
        0: if (in_valid) begin
          exp_q.push_back(sha_compress(init_state(), msg_in));
          m_st  = 1;
          m_cnt = 0;
        end
        1: begin
          m_cnt++;
          if (m_cnt == MAIN_ITERS) m_st = 2;
        end
        default: if (out_ready) m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk({in_ready, out_valid, busy} == {m_st == 0, m_st == 2, m_st == 1}, "ctl",
          {in_ready, out_valid, busy}, {m_st == 0, m_st == 2, m_st == 1});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out", hash_out, '0);
        end else begin
          chk(hash_out == exp_q[0], "hash", hash_out, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [511:0] m, input logic [255:0] mid);
    int n = 0;
    @(posedge clk);
    #1;
    in_valid    = 1'b1;
    msg_in      = m;
    midstate_in = mid;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(in_ready, "accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_out(output logic [255:0] h);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(out_valid, "out_timeout", out_valid, 1);
    h = hash_out;
  endtask

  initial begin
    bit           seen [5];
    int           lat  [5];
    logic [255:0] hv   [5];
    logic [255:0] h, hb;
    logic         v;
`ifdef SHA256_MIDSTATE_EN
    logic [511:0] blk1, blk2;
`endif

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    msg_in      = '0;
    midstate_in = IV;
    #12;
    chk(in_ready && !out_valid && !busy, "reset_ctl", {in_ready, out_valid, busy}, 3'b100);
    chk(hash_out == '0, "reset_hash", hash_out, '0);
    chk(alt_ir == 4'hf && alt_busy == 4'h0, "reset_alt", {alt_ir, alt_busy}, 8'hf0);
    @(posedge clk);
    #1 rst = 1'b0;

    // "abc" through all five round widths at once.
    for (int g = 0; g < 5; g++) seen[g] = 1'b0;
    send(ABC_MSG, IV);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++) begin
        if (g < 4) begin
          v = alt_ov[g];
          h = alt_hash[g];
        end else begin
          v = out_valid;
          h = hash_out;
        end
        if (v && !seen[g]) begin
          seen[g] = 1'b1;
          lat[g]  = cyc - acc_cyc;
          hv[g]   = h;
        end
      end
    end
    for (int g = 0; g < 5; g++) begin
      chk(seen[g] && lat[g] == 64 / ALT_R[g], $sformatf("latency_R%0d", ALT_R[g]),
          seen[g] ? lat[g] : -1, 64 / ALT_R[g]);
      chk(seen[g] && hv[g] == ABC_HASH, $sformatf("abc_R%0d", ALT_R[g]), hv[g], ABC_HASH);
    end

`ifdef SHA256_MIDSTATE_EN
    blk1 = {32'h00000000, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70, 32'h6c6d6e6f, 32'h6b6c6d6e,
            32'h6a6b6c6d, 32'h696a6b6c, 32'h68696a6b, 32'h6768696a, 32'h66676869, 32'h65666768,
            32'h64656667, 32'h63646566, 32'h62636465, 32'h61626364};
    blk2 = {32'h000001c0, 480'h0};
    send(blk1, IV);
    wait_out(h);
    send(blk2, h);
    wait_out(h);
    chk(h == {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459, 32'h0c3e6039,
              32'he5c02693, 32'hd20638b8, 32'h248d6a61}, "two_block", h,
        {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459, 32'h0c3e6039,
         32'he5c02693, 32'hd20638b8, 32'h248d6a61});
`endif

    // Backpressure with a second block waiting.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send({16{$urandom()}}, IV);
    wait_out(hb);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    msg_in   = {16{32'hdeadbeef}};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    chk(hash_out == hb && out_valid && !in_ready, "bp_hold", hash_out, hb);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(in_ready && !out_valid, "bp_ready_rise", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    chk(busy && !in_ready, "bp_accept_2nd_edge", {busy, in_ready}, 2'b10);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(h);

    // Asynchronous reset with rcnt at 24.
    send(ABC_MSG, IV);
    for (int i = 0; i < 6; i++) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk(in_ready && !out_valid && !busy, "midrun_reset_ctl", {in_ready, out_valid, busy}, 3'b100);
    chk(hash_out == '0, "midrun_reset_hash", hash_out, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) @(posedge clk);
    send(ABC_MSG, IV);
    wait_out(h);
    chk(h == ABC_HASH, "abc_after_reset", h, ABC_HASH);

    // Input churn: random data, valid pulses and backpressure every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 16; k++) msg_in[32*k +: 32] = $urandom();
      for (int k = 0; k < 8; k++) midstate_in[32*k +: 32] = $urandom();
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (m_st != 0 || exp_q.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    chk(exp_q.size() == 0 && in_ready, "drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
